// File: rtl/sraml_pkg.sv
// Shared types and helpers for the SRAM-like responder: size codes, byte-lane
// enable decode and the layout of one in-flight response entry.
package sraml_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [31:0] word;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Size code 3 falls into the word case on purpose.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << lo;
            SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sraml_resp_fifo.sv
// In-order response queue; every entry carries its own down-counting timer so
// the head is ready exactly when its latency has elapsed.
module sraml_resp_fifo
    import sraml_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty,
    output logic   head_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(LATENCY - 1);

    entry_t        mem   [DEPTH];
    logic [TW-1:0] timer [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign head       = mem[rd_ptr];
    assign head_ready = !empty && (timer[rd_ptr] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) timer[i] <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Free slots may still count down; they are reloaded on push.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_ptr == PW'(i))
                    timer[i] <= T_LOAD;
                else if (timer[i] != '0)
                    timer[i] <= timer[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sraml_resp_ram.sv
// SRAM-like slave: on-chip word RAM answering accepted requests in order a
// fixed number of cycles after the address handshake.
module sraml_resp_ram
    import sraml_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    logic [31:0]       ram [2**ADDR_W];
    logic [ADDR_W-1:0] widx;
    logic [3:0]        be;
    logic              accept, full, empty, head_ready;
    entry_t            push_data, head;
    logic              unused;

    assign widx    = addr[ADDR_W+1:2];
    assign be      = byte_en(size, addr[1:0]);
    // full is registered, so a completion this cycle cannot free a slot early.
    assign addr_ok = rst & req & ~hold & ~full;
    assign accept  = req & addr_ok;
    assign unused  = ^{addr[31:ADDR_W+2], empty};

    // Read data is captured at accept, so it reflects all earlier writes.
    assign push_data = '{wr: wr, word: wr ? 32'h0 : ram[widx]};

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    sraml_resp_fifo #(
        .DEPTH   (OUTSTANDING),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_data  (push_data),
        .pop        (head_ready),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .head_ready (head_ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_ok <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            data_ok <= head_ready;
            if (head_ready) rdata <= head.wr ? 32'h0 : head.word;
        end
    end

endmodule

// File: tb/tb_sraml_resp_ram.sv
// Scoreboard bench for sraml_resp_ram: the driver queues hand-computed responses
// at each handshake, a negedge monitor checks handshake, latency and data.
module tb_sraml_resp_ram;

    localparam int LAT = 4;
    localparam int OUT = 2;

    logic        clk = 1'b0, rst = 1'b1, hold = 1'b0, req = 1'b0, wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          inflight = 0;
    logic [31:0] last_rdata = 32'h0;

    sraml_resp_ram #(.ADDR_W(14), .LATENCY(LAT), .OUTSTANDING(OUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            chk("rst_addr_ok", 32'(addr_ok), 32'h0);
            chk("rst_data_ok", 32'(data_ok), 32'h0);
            chk("rst_rdata", rdata, 32'h0);
            exp_q.delete();
            inflight   = 0;
            last_rdata = 32'h0;
        end else begin
            if (data_ok) begin
                inflight--;
                if (exp_q.size() == 0) begin
                    chk("spurious_data_ok", 32'(data_ok), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", 32'(cyc), 32'(e.due));
                    chk("rdata", rdata, e.data);
                end
                last_rdata = rdata;
            end else begin
                chk("rdata_hold", rdata, last_rdata);
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                chk("missing_data_ok", 32'(cyc), 32'(exp_q[0].due));
                void'(exp_q.pop_front());
            end
            chk("addr_ok", 32'(addr_ok), 32'(req & ~hold & (inflight < OUT)));
            if (req && addr_ok) inflight++;
        end
    end

    // Leaves req asserted after the handshake so calls can run back-to-back.
    task automatic do_req(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] e);
        bit got = 1'b0;
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (addr_ok) begin
                exp_q.push_back('{data: e, due: cyc + 1 + LAT});
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle();
        req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        req = 1'b0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        // T1: reset with a pending request, then release
        #1 rst = 1'b0;
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h0; wdata = 32'h1111_1111;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        do_req(1'b1, 2'd2, 32'h0, 32'h1111_1111, 32'h0);
        drain();

        // T2: word write then read
        do_req(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF, 32'h0);
        idle();
        do_req(1'b0, 2'd2, 32'h100, 32'h0, 32'hDEAD_BEEF);
        drain();

        // T3: byte/half lanes, size 3, aliasing
        do_req(1'b1, 2'd2, 32'h200, 32'h0, 32'h0);
        do_req(1'b1, 2'd0, 32'h201, 32'h0000_AA00, 32'h0);
        do_req(1'b1, 2'd1, 32'h202, 32'hBBCC_0000, 32'h0);
        do_req(1'b0, 2'd2, 32'h200, 32'h0, 32'hBBCC_AA00);
        do_req(1'b0, 2'd2, 32'h0001_0200, 32'h0, 32'hBBCC_AA00);
        do_req(1'b1, 2'd1, 32'h203, 32'h1234_0000, 32'h0);
        do_req(1'b0, 2'd0, 32'h200, 32'h0, 32'h1234_AA00);
        do_req(1'b1, 2'd3, 32'h20B, 32'h5566_7788, 32'h0);
        do_req(1'b1, 2'd0, 32'h20B, 32'h9900_0000, 32'h0);
        do_req(1'b0, 2'd2, 32'h208, 32'h0, 32'h9966_7788);
        drain();

        // T4: back-pressure with req held across six reads
        for (int i = 0; i < 6; i++)
            do_req(1'b1, 2'd2, 32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 32'h0);
        drain();
        for (int i = 0; i < 6; i++)
            do_req(1'b0, 2'd2, 32'h400 + 32'(4 * i), 32'h0, 32'hA000_0000 + 32'(i));
        drain();

        // T5: hold while two reads are in flight
        do_req(1'b0, 2'd2, 32'h400, 32'h0, 32'hA000_0000);
        do_req(1'b0, 2'd2, 32'h404, 32'h0, 32'hA000_0001);
        hold = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h408;
        repeat (8) @(posedge clk);
        #1 hold = 1'b0;
        do_req(1'b0, 2'd2, 32'h408, 32'h0, 32'hA000_0002);
        drain();

        // T6: reset pulse with a write and a read in flight
        do_req(1'b1, 2'd2, 32'h300, 32'hCAFE_F00D, 32'h0);
        do_req(1'b0, 2'd2, 32'h100, 32'h0, 32'hDEAD_BEEF);
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        do_req(1'b0, 2'd2, 32'h300, 32'h0, 32'hCAFE_F00D);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
